// File: rtl/temp_monitor.sv
// Multi-channel temperature monitor: averages N channels per sample and raises a
// persistence-filtered, hysteresis-cleared alarm. Optional TEMP_MON_MAX_EN adds max_temp.
module temp_monitor #(
  parameter int W       = 16,
  parameter int N       = 4,
  parameter int PERSIST = 3,
  parameter int HYST    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_valid,
  input  logic [N*W-1:0] temps,
  input  logic [W-1:0]   threshold,
  output logic [W-1:0]   avg,
  output logic           avg_valid,
  output logic [1:0]     state,
`ifdef TEMP_MON_MAX_EN
  output logic [W-1:0]   max_temp,
`endif
  output logic           too_hot
);

  localparam int          LOG2N     = (N > 1) ? $clog2(N) : 0;
  localparam int          SW        = W + LOG2N;
  localparam logic [3:0]  PERSIST_C = 4'(PERSIST);
  localparam logic [W-1:0] HYST_W   = W'(HYST);

  localparam logic [1:0] ST_COOL = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_HOT  = 2'd2;

  // Sum is carried at W+log2(N) bits so no channel combination can wrap.
  function automatic logic [W-1:0] chan_avg(input logic [N*W-1:0] t);
    logic [SW-1:0] acc;
    acc = {SW{1'b0}};
    for (int i = 0; i < N; i++) begin
      acc = acc + SW'(t[i*W +: W]);
    end
    return W'(acc >> LOG2N);
  endfunction

  function automatic logic [W-1:0] chan_max(input logic [N*W-1:0] t);
    logic [W-1:0] m;
    m = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (t[i*W +: W] > m) begin
        m = t[i*W +: W];
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  // Clear level for HOT; floors at zero so a zero threshold latches the alarm.
  function automatic logic [W-1:0] sat_sub_hyst(input logic [W-1:0] a);
    return (a > HYST_W) ? (a - HYST_W) : {W{1'b0}};
  endfunction

  logic [W-1:0] avg_r;
  logic         avg_valid_r;
  logic [W-1:0] thr_r;
  logic [W-1:0] avg_s;
  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [3:0]   cnt_r;
  logic [3:0]   cnt_nxt_s;
  logic [3:0]   cnt_inc_s;
  logic         too_hot_r;
  logic         too_hot_nxt_s;
  logic         over_s;
  logic [W-1:0] hot_exit_s;
`ifdef TEMP_MON_MAX_EN
  logic [W-1:0] max_r;
  logic [W-1:0] max_s;
`endif

  // Channel reduction for the incoming sample.
  always_comb begin
    avg_s = chan_avg(temps);
`ifdef TEMP_MON_MAX_EN
    max_s = chan_max(temps);
`endif
  end

  // Sample capture: avg, paired threshold and the one-cycle avg_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_r       <= {W{1'b0}};
      avg_valid_r <= 1'b0;
      thr_r       <= {W{1'b0}};
`ifdef TEMP_MON_MAX_EN
      max_r       <= {W{1'b0}};
`endif
    end else begin
      avg_valid_r <= sample_valid;
      if (sample_valid) begin
        avg_r <= avg_s;
        thr_r <= threshold;
`ifdef TEMP_MON_MAX_EN
        max_r <= max_s;
`endif
      end
    end
  end

  // Over-threshold decision and HOT exit level for the pending average.
  always_comb begin
    hot_exit_s = sat_sub_hyst(thr_r);
    cnt_inc_s  = cnt_r + 4'd1;
`ifdef TEMP_MON_MAX_EN
    over_s     = (avg_r > thr_r) || (max_r > thr_r);
`else
    over_s     = (avg_r > thr_r);
`endif
  end

  // FSM state register; alarm is registered alongside so it tracks state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_COOL;
      cnt_r     <= 4'd0;
      too_hot_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      too_hot_r <= too_hot_nxt_s;
    end
  end

  // FSM next state: advances only when a fresh average is presented.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (avg_valid_r) begin
      case (state_r)
        ST_WARM: begin
          if (over_s) begin
            cnt_nxt_s   = cnt_inc_s;
            state_nxt_s = (cnt_inc_s >= PERSIST_C) ? ST_HOT : ST_WARM;
          end else begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_COOL;
          end
        end
        ST_HOT: begin
          if (avg_r < hot_exit_s) begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_COOL;
          end else begin
            cnt_nxt_s   = cnt_r;
            state_nxt_s = ST_HOT;
          end
        end
        // COOL, and the unused encoding which behaves as COOL.
        default: begin
          if (over_s) begin
            cnt_nxt_s   = 4'd1;
            state_nxt_s = (PERSIST_C == 4'd1) ? ST_HOT : ST_WARM;
          end else begin
            cnt_nxt_s   = 4'd0;
            state_nxt_s = ST_COOL;
          end
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // FSM output decode for the next registered alarm value.
  always_comb begin
    too_hot_nxt_s = (state_nxt_s == ST_HOT);
  end

  assign avg       = avg_r;
  assign avg_valid = avg_valid_r;
  assign state     = state_r;
  assign too_hot   = too_hot_r;
`ifdef TEMP_MON_MAX_EN
  assign max_temp  = max_r;
`endif

endmodule

// File: tb/tb_temp_monitor.sv
// Self-checking bench for temp_monitor: directed scenarios plus randomized samples,
// all checked against an arithmetic reference model (max_temp checked under TEMP_MON_MAX_EN).
module tb_temp_monitor;

  localparam int W       = 16;
  localparam int N       = 4;
  localparam int PERSIST = 3;
  localparam int HYST    = 1;

  logic           clk;
  logic           rst;
  logic           sample_valid;
  logic [N*W-1:0] temps;
  logic [W-1:0]   threshold;
  logic [W-1:0]   avg;
  logic           avg_valid;
  logic [1:0]     state;
  logic           too_hot;
`ifdef TEMP_MON_MAX_EN
  logic [W-1:0]   max_temp;
`endif

  temp_monitor #(.W(W), .N(N), .PERSIST(PERSIST), .HYST(HYST)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .temps        (temps),
    .threshold    (threshold),
    .avg          (avg),
    .avg_valid    (avg_valid),
    .state        (state),
`ifdef TEMP_MON_MAX_EN
    .max_temp     (max_temp),
`endif
    .too_hot      (too_hot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integers, alarm as a flag plus a run length of over averages.
  longint m_avg = 0;
  longint m_thr = 0;
  longint m_max = 0;
  bit     m_av  = 1'b0;
  bit     m_hot = 1'b0;
  int     m_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] t;
    t = {16'(d), 16'(c), 16'(b), 16'(a)};
    return t;
  endfunction

  function automatic int exp_state();
    if (m_hot) return 2;
    else if (m_run > 0) return 1;
    else return 0;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [N*W-1:0] t, input logic [W-1:0] th);
    longint s;
    longint mx;
    bit over;
    if (r) begin
      m_avg = 0; m_thr = 0; m_max = 0; m_av = 1'b0; m_hot = 1'b0; m_run = 0;
    end else begin
      if (m_av) begin
        over = (m_avg > m_thr);
`ifdef TEMP_MON_MAX_EN
        over = over || (m_max > m_thr);
`endif
        if (m_hot) begin
          if (m_avg + HYST < m_thr) begin
            m_hot = 1'b0; m_run = 0;
          end
        end else if (over) begin
          m_run = m_run + 1;
          if (m_run >= PERSIST) m_hot = 1'b1;
        end else begin
          m_run = 0;
        end
      end
      m_av = v;
      if (v) begin
        s = 0; mx = 0;
        for (int i = 0; i < N; i++) begin
          s = s + longint'(t[i*W +: W]);
          if (longint'(t[i*W +: W]) > mx) mx = longint'(t[i*W +: W]);
        end
        m_avg = s / N;
        m_max = mx;
        m_thr = longint'(th);
      end
    end
  endtask

  // One clock: drive at negedge, model the edge, compare at the following negedge.
  task automatic step(input bit r, input bit v, input logic [N*W-1:0] t, input logic [W-1:0] th);
    rst = r; sample_valid = v; temps = t; threshold = th;
    @(posedge clk);
    model_edge(r, v, t, th);
    @(negedge clk);
    check_eq("avg",       32'(avg),       32'(m_avg));
    check_eq("avg_valid", 32'(avg_valid), 32'(m_av));
    check_eq("state",     32'(state),     32'(exp_state()));
    check_eq("too_hot",   32'(too_hot),   32'(m_hot));
`ifdef TEMP_MON_MAX_EN
    check_eq("max_temp",  32'(max_temp),  32'(m_max));
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, pk(0, 0, 0, 0), 16'd0);
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; temps = '0; threshold = '0;

    step(1'b1, 1'b0, pk(0, 0, 0, 0), 16'd0);
    step(1'b1, 1'b1, pk(9, 9, 9, 9), 16'd1);
    check_eq("rst_avg",   32'(avg),       32'd0);
    check_eq("rst_valid", 32'(avg_valid), 32'd0);
    check_eq("rst_state", 32'(state),     32'd0);
    check_eq("rst_hot",   32'(too_hot),   32'd0);

    // Alarm after three consecutive over averages.
    step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    check_eq("alarm_avg1", 32'(avg), 32'd3);
    step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    check_eq("alarm_st1", 32'(state), 32'd1);
    step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    check_eq("alarm_st2", 32'(state), 32'd1);
    idle();
    check_eq("alarm_st3", 32'(state),   32'd2);
    check_eq("alarm_hot", 32'(too_hot), 32'd1);

    // Hysteresis: avg equal to threshold holds HOT, zero clears it.
    step(1'b0, 1'b1, pk(2, 2, 2, 2), 16'd2);
    idle();
    check_eq("hyst_hold", 32'(state), 32'd2);
    step(1'b0, 1'b1, pk(0, 0, 0, 0), 16'd2);
    idle();
    check_eq("hyst_clr",     32'(state),   32'd0);
    check_eq("hyst_clr_hot", 32'(too_hot), 32'd0);

    // Broken persistence restarts from WARM.
    step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    step(1'b0, 1'b1, pk(2, 2, 2, 2), 16'd2);
    check_eq("brk_warm", 32'(state), 32'd1);
    idle();
    check_eq("brk_cool", 32'(state), 32'd0);
    step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    idle();
    check_eq("brk_restart", 32'(state), 32'd1);

    // Width: no wrap of the channel sum.
    step(1'b0, 1'b1, pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF);
    check_eq("wide_all", 32'(avg), 32'h0000FFFF);
    step(1'b0, 1'b1, pk(16'hFFFF, 1, 0, 0), 16'hFFFF);
    check_eq("wide_mix", 32'(avg), 32'h00004000);

    // Reset while HOT clears everything with no trailing pulse.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pk(2, 2, 4, 4), 16'd2);
    idle();
    check_eq("pre_rst_hot", 32'(state), 32'd2);
    step(1'b0, 1'b1, pk(5, 5, 5, 5), 16'd2);
    step(1'b1, 1'b0, pk(0, 0, 0, 0), 16'd0);
    check_eq("rst_hot_state", 32'(state),     32'd0);
    check_eq("rst_hot_valid", 32'(avg_valid), 32'd0);
    idle();
    check_eq("rst_no_pulse",  32'(avg_valid), 32'd0);

`ifdef TEMP_MON_MAX_EN
    step(1'b0, 1'b1, pk(0, 0, 0, 9), 16'd5);
    check_eq("max_avg", 32'(avg),      32'd2);
    check_eq("max_val", 32'(max_temp), 32'd9);
    idle();
    check_eq("max_warm", 32'(state), 32'd1);
`endif

    // Randomized traffic around the threshold, with occasional wide values and resets.
    for (int k = 0; k < 600; k++) begin
      logic [N*W-1:0] t;
      logic [W-1:0]   th;
      bit r, v;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) t[i*W +: W] = 16'($urandom);
        else t[i*W +: W] = 16'($urandom_range(0, 24));
      end
      th = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      step(r, v, t, th);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/temp_monitor.md
TEMP_MONITOR -- requirements
Module: temp_monitor

Interface
REQ-001 SHALL have parameter W, default 16, meaning the bit width of each temperature channel and of the threshold.
REQ-002 SHALL have parameter N, default 4, meaning the channel count; legal values are powers of two from 1 to 16.
REQ-003 SHALL have parameter PERSIST, default 3, meaning the number of consecutive over-threshold averages required before alarm; legal values are 1 to 15.
REQ-004 SHALL have parameter HYST, default 1, meaning the hysteresis margin below threshold required to clear the alarm.
REQ-005 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port sample_valid  input  1  qualifies temps and threshold for one cycle.
REQ-008 SHALL have port temps  input  N*W  packed unsigned channels, with channel i at [i*W +: W].
REQ-009 SHALL have port threshold  input  W  unsigned limit, sampled together with temps.
REQ-010 SHALL have port avg  output  W  registered channel average.
REQ-011 SHALL have port avg_valid  output  1  one-cycle pulse marking a new avg.
REQ-012 SHALL have port state  output  2  FSM state: COOL=0, WARM=1, HOT=2; value 3 is unused.
REQ-013 SHALL have port too_hot  output  1  alarm, equal to (state==HOT).

Function
REQ-014 SHALL, when sample_valid=1 at edge t, compute sum = sum of N channels at width W+log2(N) with no overflow, and load avg = sum >> log2(N) (truncating) at edge t.
REQ-015 SHALL register threshold at edge t and pair it with that avg.
REQ-016 SHALL pulse avg_valid high for exactly the cycle after edge t; back-to-back sample_valid SHALL produce back-to-back pulses.
REQ-017 SHALL update the FSM only on edges where avg_valid=1, so that state changes at edge t+1; cycles with sample_valid=0 hold all state.
REQ-018 SHALL define over = (avg > threshold_reg) as an unsigned compare.
REQ-019 SHALL apply these transitions from COOL: on over, go to WARM with cnt=1, or directly to HOT if PERSIST==1; otherwise stay in COOL with cnt=0.
REQ-020 SHALL apply these transitions from WARM: on over, increment cnt and go to HOT when cnt reaches PERSIST; on not over, go to COOL with cnt=0.
REQ-021 SHALL apply these transitions from HOT: go to COOL with cnt=0 only when avg < threshold_reg - HYST; ignore over.
REQ-022 SHALL compute threshold_reg - HYST saturating at 0, so with threshold 0 the HOT state is never exited except by reset.
REQ-023 SHALL treat unused state value 3 as COOL on its next update.
REQ-024 SHALL NOT take any input-side backpressure; every valid sample is consumed.

Reset
REQ-025 SHALL, while rst=1 at an edge, force avg=0, avg_valid=0, state=COOL, cnt=0, too_hot=0 and threshold_reg=0.
REQ-026 SHALL give rst priority over sample_valid in the same cycle, discarding that sample.
REQ-027 SHALL, on reset mid-WARM or mid-HOT, clear everything on that edge with no pending avg_valid pulse afterward.

Configuration
REQ-028 SHALL, with TEMP_MON_MAX_EN defined, add output max_temp (W bits) holding the largest channel of the last sample, reset to 0 and updated at the same edge as avg.
REQ-029 SHALL, with TEMP_MON_MAX_EN defined, redefine over = (avg > threshold_reg) OR (max_temp > threshold_reg).
REQ-030 SHALL, without TEMP_MON_MAX_EN, omit the max_temp port and logic entirely and use over as defined in REQ-018.

Verification (W=16, N=4, PERSIST=3, HYST=1)
REQ-031 SHALL cover reset: assert rst for 2 cycles -> avg=0, avg_valid=0, state=0, too_hot=0.
REQ-032 SHALL cover alarm assertion: temps {2,2,4,4} with threshold 2, for 3 valid samples -> avg=3 each; state goes 1, 1, 2; too_hot=1 one edge after the third avg_valid.
REQ-033 SHALL cover hysteresis: in HOT, temps {2,2,2,2} with threshold 2 -> stays HOT (2 is not < 1); then temps {0,0,0,0} -> COOL and too_hot=0.
REQ-034 SHALL cover broken persistence: 2 samples at avg 3, then avg 2, with threshold 2 -> state 1, 1, 0; a following avg 3 restarts at WARM with cnt=1.
REQ-035 SHALL cover width: all channels 16'hFFFF -> avg=16'hFFFF with no wrap; {16'hFFFF,1,0,0} -> avg=16'h4000.
REQ-036 SHALL cover reset mid-HOT and the macro: rst while HOT -> state=0 next edge; with TEMP_MON_MAX_EN, temps {0,0,0,9} with threshold 5 -> avg=2, max_temp=9, state=WARM.
